mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_priority.sv | 44 ++++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the unified I/D memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  // Streak counter width; a zero burst limit still needs one storage bit.
  function automatic int streak_w(input int max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_priority.sv
// Winner pick for the shared bus: data first, fetch forced through after a
// run of MAX_D_BURST data grants while a fetch is waiting.
module arb_priority
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic d_req,
  input  logic idle,
  input  logic i_flush,
  output logic i_win,
  output logic d_win
);

  localparam int SW = streak_w(MAX_D_BURST);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_BURST);

  logic [SW-1:0] d_streak;
  logic          i_ok;
  logic          force_i;

  // Combinational pick; a flushed fetch never competes.
  always_comb begin
    i_ok    = i_req && !i_flush;
    force_i = (MAX_D_BURST != 0) && (d_streak == STREAK_MAX);
    d_win   = idle && d_req && !(i_ok && force_i);
    i_win   = idle && i_ok && (!d_req || force_i);
  end

  // Saturating count of data grants that overtook a pending fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_streak <= '0;
    end else if (!i_req || i_win) begin
      d_streak <= '0;
    end else if (d_win && (d_streak != STREAK_MAX)) begin
      d_streak <= d_streak + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port arbiter sharing one memory bus between fetch (I) and data (D).
// One transaction outstanding; a flushed fetch completes silently.
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   ARB_IDLE   | bus free, winner granted combinationally
//   ARB_BUSY_I | fetch command on m_*, waiting for m_ack
//   ARB_BUSY_D | data command on m_*, waiting for m_ack
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [BE_W-1:0]   m_be,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_e state, next_state;
  logic       idle;
  logic       i_win, d_win;
  logic       drop;

  assign idle = (state == ARB_IDLE);

  arb_priority #(.MAX_D_BURST(MAX_D_BURST)) u_prio (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (i_req),
    .d_req  (d_req),
    .idle   (idle),
    .i_flush(i_flush),
    .i_win  (i_win),
    .d_win  (d_win)
  );

  // Grants are held low while reset is asserted.
  assign i_gnt = i_win && rst_n;
  assign d_gnt = d_win && rst_n;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= next_state;
  end

  // Next-state: leave IDLE on a grant, return on m_ack.
  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: begin
        if (d_win)      next_state = ARB_BUSY_D;
        else if (i_win) next_state = ARB_BUSY_I;
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (m_ack) next_state = ARB_IDLE;
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  // Memory command: captured at grant, held until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_be    <= '0;
    end else if (idle && d_win) begin
      m_req   <= 1'b1;
      m_we    <= d_we;
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
      m_be    <= d_be;
    end else if (idle && i_win) begin
      m_req   <= 1'b1;
      m_we    <= 1'b0;
      m_addr  <= i_addr;
      m_wdata <= '0;
      m_be    <= '1;
    end else if (!idle && m_ack) begin
      m_req   <= 1'b0;
    end
  end

  // Response capture; flush on the ack cycle itself also suppresses i_rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if ((state == ARB_BUSY_I) && m_ack && !drop && !i_flush) begin
        i_rvalid <= 1'b1;
        i_rdata  <= m_rdata;
      end
      if ((state == ARB_BUSY_D) && m_ack) begin
        d_rvalid <= 1'b1;
        d_rdata  <= m_we ? '0 : m_rdata;
      end
    end
  end

  // Drop flag: remembers a flush seen while a fetch is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop <= 1'b0;
    end else if (state == ARB_BUSY_I) begin
      if (m_ack)        drop <= 1'b0;
      else if (i_flush) drop <= 1'b1;
    end else begin
      drop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_flush;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_ack;
  logic [31:0] m_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.MAX_D_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    i_req = 1'b1; i_addr = 32'h0; i_flush = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    m_ack = 1'b0; m_rdata = 32'h0;

    // Reset state, requests asserted during reset must not be granted.
    #3;
    check_val("rst_i_gnt", i_gnt, 0);
    check_val("rst_d_gnt", d_gnt, 0);
    check_val("rst_m_req", m_req, 0);
    check_val("rst_m_addr", m_addr, 0);
    check_val("rst_rvalid", {i_rvalid, d_rvalid}, 0);
    check_val("rst_rdata", i_rdata | d_rdata, 0);
    i_req = 1'b0; d_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Lone fetch: grant at 0, ack at 3, rvalid at 4.
    i_req = 1'b1; i_addr = 32'h100;
    #1 check_val("fetch_i_gnt", i_gnt, 1);
    check_val("fetch_d_gnt", d_gnt, 0);
    step(); i_req = 1'b0;
    #1 check_val("fetch_m_req_c1", m_req, 1);
    check_val("fetch_m_addr_c1", m_addr, 32'h100);
    check_val("fetch_m_we", m_we, 0);
    check_val("fetch_busy_gnt", i_gnt, 0);
    step();
    #1 check_val("fetch_m_addr_c2", m_addr, 32'h100);
    step(); m_ack = 1'b1; m_rdata = 32'h00000013;
    #1 check_val("fetch_m_addr_c3", m_addr, 32'h100);
    check_val("fetch_no_early_rvalid", i_rvalid, 0);
    step(); m_ack = 1'b0;
    #1 check_val("fetch_i_rvalid", i_rvalid, 1);
    check_val("fetch_i_rdata", i_rdata, 32'h13);
    check_val("fetch_m_req_low", m_req, 0);
    check_val("fetch_d_rvalid", d_rvalid, 0);
    step();
    #1 check_val("fetch_rvalid_pulse", i_rvalid, 0);

    // Simultaneous: D write wins, I granted in the cycle after D completes.
    i_req = 1'b1; i_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hAABBCCDD; d_be = 4'hF;
    #1 check_val("sim_d_gnt", d_gnt, 1);
    check_val("sim_i_gnt", i_gnt, 0);
    step(); d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h12345678;
    #1 check_val("sim_m_we", m_we, 1);
    check_val("sim_m_addr", m_addr, 32'h200);
    check_val("sim_m_wdata", m_wdata, 32'hAABBCCDD);
    check_val("sim_m_be", m_be, 4'hF);
    check_val("sim_busy_i_gnt", i_gnt, 0);
    step(); m_ack = 1'b0;
    #1 check_val("sim_d_rvalid", d_rvalid, 1);
    check_val("sim_d_rdata_wr", d_rdata, 0);
    check_val("sim_i_gnt_after", i_gnt, 1);
    step(); i_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h00000093;
    #1 check_val("sim_i_m_addr", m_addr, 32'h104);
    check_val("sim_i_m_we", m_we, 0);
    step(); m_ack = 1'b0;
    #1 check_val("sim_i_rvalid", i_rvalid, 1);
    check_val("sim_i_rdata", i_rdata, 32'h93);
    step();

    // Starvation: both held, order D,D,D,D,I,D,D,D,D,I.
    i_req = 1'b1; i_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    for (int g = 0; g < 10; g++) begin
      logic exp_i;
      exp_i = (g == 4) || (g == 9);
      #1 check_val($sformatf("starve_i_gnt_%0d", g), i_gnt, exp_i);
      check_val($sformatf("starve_d_gnt_%0d", g), d_gnt, !exp_i);
      step(); m_ack = 1'b1; m_rdata = 32'h1000 + g;
      #1 check_val($sformatf("starve_m_req_%0d", g), m_req, 1);
      step(); m_ack = 1'b0;
      #1 check_val($sformatf("starve_i_rv_%0d", g), i_rvalid, exp_i);
      check_val($sformatf("starve_d_rv_%0d", g), d_rvalid, !exp_i);
    end
    i_req = 1'b0; d_req = 1'b0;
    step();

    // Flush while idle blocks the fetch grant.
    i_req = 1'b1; i_flush = 1'b1; i_addr = 32'h108;
    #1 check_val("idle_flush_i_gnt", i_gnt, 0);
    i_flush = 1'b0;
    #1 check_val("idle_noflush_i_gnt", i_gnt, 1);
    // Flush in flight: granted at 0, flush at 2, ack at 3 -> no rvalid.
    step(); i_req = 1'b0;
    step(); i_flush = 1'b1;
    step(); i_flush = 1'b0; m_ack = 1'b1; m_rdata = 32'h55;
    step(); m_ack = 1'b0; i_req = 1'b1; i_addr = 32'h10C;
    #1 check_val("flush_no_rvalid", i_rvalid, 0);
    check_val("flush_next_gnt", i_gnt, 1);
    step(); i_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h66;
    step(); m_ack = 1'b0;
    #1 check_val("flush_clear_rvalid", i_rvalid, 1);
    check_val("flush_clear_rdata", i_rdata, 32'h66);
    step();

    // Async reset mid BUSY_D, pending ack ignored.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2F0;
    #1 check_val("ar_d_gnt", d_gnt, 1);
    step(); d_req = 1'b0;
    #1 check_val("ar_m_req_busy", m_req, 1);
    #1 rst_n = 1'b0;
    #1 check_val("ar_m_req_async", m_req, 0);
    check_val("ar_m_addr_async", m_addr, 0);
    m_ack = 1'b1; m_rdata = 32'hBAD0BAD0;
    step();
    step(); m_ack = 1'b0; rst_n = 1'b1;
    #1 check_val("ar_no_d_rvalid", d_rvalid, 0);
    check_val("ar_no_i_rvalid", i_rvalid, 0);
    d_req = 1'b1; d_addr = 32'h300;
    #1 check_val("ar_post_d_gnt", d_gnt, 1);
    step(); d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
    #1 check_val("ar_post_m_addr", m_addr, 32'h300);
    step(); m_ack = 1'b0;
    #1 check_val("ar_post_d_rvalid", d_rvalid, 1);
    check_val("ar_post_d_rdata", d_rdata, 32'hDEADBEEF);
    step();

    // Ack while idle: no rvalid, state still idle (next request granted).
    m_ack = 1'b1; m_rdata = 32'h77;
    step(); m_ack = 1'b0;
    #1 check_val("idle_ack_i_rvalid", i_rvalid, 0);
    check_val("idle_ack_d_rvalid", d_rvalid, 0);
    check_val("idle_ack_m_req", m_req, 0);
    d_req = 1'b1; d_addr = 32'h600;
    #1 check_val("idle_ack_still_idle", d_gnt, 1);
    step(); d_req = 1'b0; m_ack = 1'b1;
    step(); m_ack = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
